rv_sim_monitor: RTL
===================

Name: rv_sim_monitor

Overview:
- Synthesizable run monitor that snoops the CPU data-memory write bus and PC debug port.
- Decides the PASS / FAIL / TIMEOUT verdict in RTL instead of by bench polling, and adds PC-stall hang detection and a byte console channel.
- Sits beside the CPU in simulation and FPGA top levels. Benches only wait on `done`.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, word address of the tohost mailbox; compared on addr[31:2].
- CONSOLE_ADDR, 32'h0000_1004, word address of the console byte port; compared on addr[31:2].
- MAX_CYCLES, 200000, run-cycle budget before TIMEOUT; must be >= 1.
- HANG_CYCLES, 1024, consecutive cycles of unchanged pc_debug that declare HANG; 0 disables hang detection.
- CNT_W, 32, width of the cycle and stall counters; must hold MAX_CYCLES and HANG_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_we  in  1  data-memory write enable, snooped.
- mem_addr  in  32  data-memory byte address.
- mem_wdata  in  32  data-memory write data.
- mem_wmask  in  4  byte-lane write mask; bit i covers wdata[8i+7:8i].
- pc_debug  in  32  CPU program counter.
- done  out  1  verdict reached; sticky until reset.
- pass  out  1  tohost resolved to 1.
- fail  out  1  tohost resolved to a nonzero value other than 1.
- timeout  out  1  MAX_CYCLES exhausted.
- hang  out  1  PC stalled for HANG_CYCLES cycles.
- status_code  out  32  tohost value that ended the run; 0 otherwise.
- cycle_count  out  CNT_W  RUN cycles elapsed; frozen once a verdict is reached.
- console_valid  out  1  one-cycle pulse per console byte.
- console_data  out  8  console byte; valid while console_valid=1.

Behaviour:
- Reset values: all outputs 0; state=RUN; tohost shadow, cycle_count, stall counter and last_pc cleared to 0.
- States: RUN, then one of the terminal states PASS, FAIL, TIMEOUT, HANG. Terminal states are sticky; only reset leaves them.
- Outputs `done`, `pass`, `fail`, `timeout` and `hang` are registered decodes of the state. `done` = any terminal state.
- Tohost write:
  - Condition: state RUN, mem_we=1, mem_addr[31:2]==TOHOST_ADDR[31:2].
  - The shadow is updated per lane: a lane with wmask=1 takes the wdata byte; other lanes keep their value.
  - The merged value is evaluated in the same edge. Merged==1 -> PASS. Merged nonzero and !=1 -> FAIL. Merged==0 -> stay RUN.
  - status_code takes the merged value on the PASS/FAIL transition.
  - Latency: verdict is visible in the cycle after the write cycle.
  - Multi-store sub-word writes accumulate; the verdict triggers on the first write that leaves the shadow nonzero.
- Cycle counter:
  - Increments every RUN cycle.
  - If cycle_count==MAX_CYCLES-1 at an edge and no higher-priority event occurs -> TIMEOUT; cycle_count then reads MAX_CYCLES.
- Hang detection (HANG_CYCLES>0):
  - Each RUN edge compares pc_debug with last_pc.
  - Equal -> stall counter +1, saturating at HANG_CYCLES. Different -> stall counter cleared. last_pc is updated every edge.
  - When the stall counter reaches HANG_CYCLES -> HANG.
  - The first cycle after reset compares against last_pc=0.
- Priority for the same edge: tohost verdict > HANG > TIMEOUT.
- Console:
  - Condition: state RUN, mem_we=1, addr matches CONSOLE_ADDR, wmask[0]=1.
  - Response: console_valid=1 for exactly one cycle after the write; console_data=wdata[7:0], held until the next console write.
  - No console pulses once terminal.
  - A console write in the same cycle as a verdict-causing tohost write cannot occur (single bus). Each is handled independently.
- After a terminal state: snooped writes are ignored; cycle_count, status_code and the shadow freeze.
- Reset asserted mid-run or in a terminal state: everything returns to reset values on that edge.
- The block never drives the bus. It is observation-only.

Test Plan:
- After reset, a full-word write of 32'h1 to 32'h1000 at cycle 50 -> done=1, pass=1, status_code=1 the next cycle; cycle_count frozen at 51.
- Byte write (wmask=4'b0001) of 0x07 to 32'h1000 -> fail=1, status_code=32'h7, one cycle later; a subsequent write of 1 leaves fail=1.
- Sub-word accumulation: wmask=4'b0010 with wdata=0 (shadow stays 0, no verdict), then wmask=4'b0001 with 0x01 -> pass=1.
- MAX_CYCLES=100, PC incrementing, no tohost write -> timeout=1 after exactly 100 RUN cycles, cycle_count=100; a tohost write of 1 on cycle 99 instead -> pass=1, timeout=0.
- HANG_CYCLES=8, pc_debug held at 32'h80 -> hang=1 on the 8th consecutive equal edge; PC changing every 7 cycles -> no hang. HANG_CYCLES=0 -> never hang.
- Writes of 'H','i' to 32'h1004 -> two single-cycle console_valid pulses with console_data 0x48 then 0x69. Assert reset during RUN with the shadow nonzero -> all outputs 0, shadow cleared.

Source files
------------

// File: rtl/rv_sim_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rv_sim_monitor
// Purpose  : Observation-only run monitor placed beside the CPU. It snoops
//            the data-memory write bus and the PC debug port and decides the
//            PASS / FAIL / TIMEOUT / HANG verdict in hardware. It also
//            provides a byte console channel.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            mem_we/addr/wdata/wmask - snooped data-memory write bus
//            pc_debug              - CPU program counter
//            done/pass/fail/timeout/hang - registered verdict flags (sticky)
//            status_code           - tohost value that ended the run
//            cycle_count           - RUN cycles elapsed, frozen at verdict
//            console_valid/data    - one-cycle pulse per console byte
// Revision : 1.0 - initial release
// ============================================================================
module rv_sim_monitor #(
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_1004,
  parameter int          MAX_CYCLES   = 200000,
  parameter int          HANG_CYCLES  = 1024,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wmask,
  input  logic [31:0]      pc_debug,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             hang,
  output logic [31:0]      status_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic             console_valid,
  output logic [7:0]       console_data
);

  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_PASS    = 3'd1;
  localparam logic [2:0] S_FAIL    = 3'd2;
  localparam logic [2:0] S_TIMEOUT = 3'd3;
  localparam logic [2:0] S_HANG    = 3'd4;

  // Addresses are compared on the word address only (byte offset ignored).
  localparam logic [31:0]      C_WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [CNT_W-1:0] C_CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HANG_LIM  = CNT_W'(HANG_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic             C_HANG_EN   = (HANG_CYCLES > 0);

  logic [2:0]       state_q, state_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      status_q, status_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic             cvalid_q, cvalid_d;
  logic [7:0]       cdata_q, cdata_d;
  logic             done_q, pass_q, fail_q, timeout_q, hang_q;

  logic             w_run;
  logic             w_tohost_hit;
  logic             w_console_hit;
  logic [31:0]      w_merged;

  always_comb begin
    w_run         = (state_q == S_RUN);
    w_tohost_hit  = w_run && mem_we &&
                    ((mem_addr & C_WORD_MASK) == (TOHOST_ADDR & C_WORD_MASK));
    w_console_hit = w_run && mem_we && mem_wmask[0] &&
                    ((mem_addr & C_WORD_MASK) == (CONSOLE_ADDR & C_WORD_MASK));

    // Byte-lane merge of the write into the tohost shadow, so that a
    // sequence of sub-word stores builds up the full mailbox value.
    w_merged = shadow_q;
    for (int i = 0; i < 4; i++) begin
      if (mem_wmask[i]) begin
        w_merged[8*i +: 8] = mem_wdata[8*i +: 8];
      end
    end

    state_d   = state_q;
    shadow_d  = shadow_q;
    status_d  = status_q;
    cycle_d   = cycle_q;
    stall_d   = stall_q;
    last_pc_d = pc_debug;
    cvalid_d  = w_console_hit;
    cdata_d   = w_console_hit ? mem_wdata[7:0] : cdata_q;

    if (w_run) begin
      cycle_d = cycle_q + C_ONE;

      if (pc_debug == last_pc_q) begin
        if (stall_q != C_HANG_LIM) begin
          stall_d = stall_q + C_ONE;
        end
      end else begin
        stall_d = '0;
      end

      if (w_tohost_hit) begin
        shadow_d = w_merged;
        if (w_merged == 32'd1) begin
          state_d  = S_PASS;
          status_d = w_merged;
        end else if (w_merged != 32'd0) begin
          state_d  = S_FAIL;
          status_d = w_merged;
        end
      end

      // Lower-priority verdicts apply only if tohost left us in RUN.
      if (state_d == S_RUN) begin
        if (C_HANG_EN && (stall_d == C_HANG_LIM)) begin
          state_d = S_HANG;
        end else if (cycle_q == C_CYC_LAST) begin
          state_d = S_TIMEOUT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RUN;
      shadow_q  <= '0;
      status_q  <= '0;
      cycle_q   <= '0;
      stall_q   <= '0;
      last_pc_q <= '0;
      cvalid_q  <= 1'b0;
      cdata_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      hang_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      status_q  <= status_d;
      cycle_q   <= cycle_d;
      stall_q   <= stall_d;
      last_pc_q <= last_pc_d;
      cvalid_q  <= cvalid_d;
      cdata_q   <= cdata_d;
      // Flags are decoded from the next state so they line up with state_q.
      done_q    <= (state_d != S_RUN);
      pass_q    <= (state_d == S_PASS);
      fail_q    <= (state_d == S_FAIL);
      timeout_q <= (state_d == S_TIMEOUT);
      hang_q    <= (state_d == S_HANG);
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign hang          = hang_q;
  assign status_code   = status_q;
  assign cycle_count   = cycle_q;
  assign console_valid = cvalid_q;
  assign console_data  = cdata_q;

endmodule
`default_nettype wire
